// File: rtl/spm_pkg.sv
// Shared state encoding and default sizing for the
// serial-parallel multiplier arbiter.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_ID_W  = $clog2(DEF_NREQ);
  localparam int DEF_CNT_W = $clog2(2 * DEF_WIDTH) + 1;

endpackage

// File: rtl/spm_core.sv
// Serial-parallel signed multiplier: one y bit per cycle.
// Ports: clk, rst, start (loads x/y), x, y, prod.
module spm_core import spm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] prod
);

  localparam int SW = $clog2(WIDTH) + 1;
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   yreg;
  logic [SW-1:0]      step;
  logic               run;

  // The y MSB carries weight -2^(WIDTH-1), so its
  // partial product is subtracted instead of added.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      yreg  <= '0;
      step  <= '0;
      run   <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      mcand <= {{WIDTH{x[WIDTH-1]}}, x};
      yreg  <= y;
      step  <= '0;
      run   <= 1'b1;
    end else if (run) begin
      if (yreg[0]) begin
        if (step == LAST)
          acc <= acc - mcand;
        else
          acc <= acc + mcand;
      end
      mcand <= mcand << 1;
      yreg  <= yreg >> 1;
      step  <= step + 1'b1;
      if (step == LAST)
        run <= 1'b0;
    end
  end

  assign prod = acc;

endmodule

// File: rtl/spm_arbiter.sv
// Round-robin arbiter sharing one serial multiplier.
// Ports: req_* operand handshake in, resp_* product out, busy.
module spm_arbiter import spm_pkg::*; #(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_x,
  input  logic [NREQ*WIDTH-1:0]    req_y,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [2*WIDTH-1:0]       resp_prod,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic                     busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(2 * WIDTH) + 1;
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(2 * WIDTH - 1);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [ID_W-1:0]    id_q;
  logic               start;
  logic [2*WIDTH-1:0] core_prod;

  logic [NREQ-1:0]    gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    idx;
  logic               gnt_any;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (gnt_any)
      gnt[gnt_id] = 1'b1;
  end

  assign req_ready =
    (state == IDLE && !rst) ? gnt : '0;
  assign busy    = (state != IDLE);
  assign resp_id = id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= '0;
      start      <= 1'b0;
      resp_valid <= 1'b0;
      resp_prod  <= '0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            x_q   <= req_x[gnt_id*WIDTH +: WIDTH];
            y_q   <= req_y[gnt_id*WIDTH +: WIDTH];
            id_q  <= gnt_id;
            cnt   <= '0;
            start <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == RUN_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_prod  <= core_prod;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            ptr        <= id_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spm_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x_q),
    .y     (y_q),
    .prod  (core_prod)
  );

endmodule

// File: tb/tb_spm_arbiter.sv
// Self-checking bench for spm_arbiter with a product
// scoreboard and a round-robin grant model.
module tb_spm_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [3:0]    req_ready;
  logic [31:0]   req_x = '0;
  logic [31:0]   req_y = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [15:0]   resp_prod;
  logic [1:0]    resp_id;
  logic          busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] prod;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   m_ptr = 0;
  logic rv_q = 1'b0;
  int   waitc[NREQ];

  spm_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_prod  (resp_prod),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] smul(
    input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb, p;
    sa = $signed({{8{a[7]}}, a});
    sb = $signed({{8{b[7]}}, b});
    p  = sa * sb;
    return p;
  endfunction

  // Scoreboard monitor: model grants, push on accept,
  // check latency, hold and products while responding.
  always @(negedge clk) begin
    exp_t f;
    int   mid;
    bit   found;
    if (rst) begin
      sbq.delete();
      m_ptr = 0;
      rv_q  = 1'b0;
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    end else begin
      if (busy) begin
        total++;
        if (req_ready !== 4'b0000) begin
          bad++;
          $display("FAIL ready_busy got=%b exp=0000",
                   req_ready);
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) waitc[i] = 0;
      if (|(req_valid & req_ready)) begin
        mid = m_ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (!found && req_valid[j]) begin
            found = 1'b1;
            mid = j;
          end
        end
        total++;
        if (req_ready !== (4'b0001 << mid)) begin
          bad++;
          $display("FAIL grant got=%b exp_id=%0d",
                   req_ready, mid);
        end
        f.id   = 2'(mid);
        f.prod = smul(req_x[mid*8 +: 8],
                      req_y[mid*8 +: 8]);
        sbq.push_back(f);
        acc_cyc = cyc;
        for (int i = 0; i < NREQ; i++) begin
          if (i == mid) waitc[i] = 0;
          else if (req_valid[i]) begin
            waitc[i]++;
            total++;
            if (waitc[i] > NREQ) begin
              bad++;
              $display("FAIL starve req=%0d got=%0d max=%0d",
                       i, waitc[i], NREQ);
            end
          end
        end
      end
      if (resp_valid && !rv_q) begin
        total++;
        if (cyc - acc_cyc != 17) begin
          bad++;
          $display("FAIL latency got=%0d exp=17",
                   cyc - acc_cyc);
        end
      end
      if (resp_valid) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_empty got=resp id=%0d exp=none",
                   resp_id);
        end else begin
          f = sbq[0];
          if (resp_prod !== f.prod || resp_id !== f.id) begin
            bad++;
            $display("FAIL sb_prod got=%h/%0d exp=%h/%0d",
                     resp_prod, resp_id, f.prod, f.id);
          end
          if (resp_ready) begin
            void'(sbq.pop_front());
            m_ptr = (int'(f.id) + 1) % NREQ;
          end
        end
      end
      rv_q = resp_valid;
    end
  end

  task automatic wait_accept(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit ok);
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_x = 32'hFFFF_FFFF;
    req_y = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    total += 5;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=0000", req_ready);
    end
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_rv got=%b exp=0", resp_valid);
    end
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b exp=0", busy);
    end
    if (resp_prod !== 16'h0) begin
      bad++;
      $display("FAIL rst_prod got=%h exp=0000", resp_prod);
    end
    if (resp_id !== 2'd0) begin
      bad++;
      $display("FAIL rst_id got=%0d exp=0", resp_id);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
  endtask

  task automatic test_single;
    bit ok;
    int a;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_x[7:0] = 8'd3;
    req_y[7:0] = 8'd5;
    req_valid = 4'b0001;
    wait_accept(10, ok);
    a = cyc;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_acc got=timeout exp=accept");
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(40, ok);
    total += 4;
    if (!ok) begin
      bad++;
      $display("FAIL single_resp got=timeout exp=resp");
    end
    if (cyc - a != 17) begin
      bad++;
      $display("FAIL single_lat got=%0d exp=17", cyc - a);
    end
    if (resp_prod !== 16'd15) begin
      bad++;
      $display("FAIL single_prod got=%h exp=000f", resp_prod);
    end
    if (resp_id !== 2'd0) begin
      bad++;
      $display("FAIL single_id got=%0d exp=0", resp_id);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_corners;
    logic [7:0]  xs[3] = '{8'h80, 8'hFF, 8'h00};
    logic [7:0]  ys[3] = '{8'h80, 8'h7F, 8'hB3};
    logic [15:0] ps[3] = '{16'h4000, 16'hFF81, 16'h0000};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      resp_ready = 1'b1;
      req_x[23:16] = xs[k];
      req_y[23:16] = ys[k];
      req_valid = 4'b0100;
      wait_accept(10, ok);
      total += 2;
      if (!ok) begin
        bad++;
        $display("FAIL corner_acc%0d got=timeout exp=accept", k);
      end
      if (req_ready !== 4'b0100) begin
        bad++;
        $display("FAIL corner_gnt%0d got=%b exp=0100",
                 k, req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp(40, ok);
      total += 2;
      if (!ok || resp_prod !== ps[k]) begin
        bad++;
        $display("FAIL corner_prod%0d got=%h exp=%h",
                 k, resp_prod, ps[k]);
      end
      if (resp_id !== 2'd2) begin
        bad++;
        $display("FAIL corner_id%0d got=%0d exp=2", k, resp_id);
      end
    end
  endtask

  task automatic test_round_robin;
    int ord[5] = '{0, 1, 2, 3, 0};
    logic [3:0] one = 4'b0001;
    int prev = 0;
    bit ok;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*8 +: 8] = 8'(17 * i + 3);
      req_y[i*8 +: 8] = 8'(250 - 37 * i);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_accept(40, ok);
      total += 2;
      if (!ok) begin
        bad++;
        $display("FAIL rr_acc%0d got=timeout exp=accept", k);
      end
      if (req_ready !== (one << ord[k])) begin
        bad++;
        $display("FAIL rr_order%0d got=%b exp_id=%0d",
                 k, req_ready, ord[k]);
      end
      if (k > 0) begin
        total++;
        if (cyc - prev != 18) begin
          bad++;
          $display("FAIL rr_gap%0d got=%0d exp=18",
                   k, cyc - prev);
        end
      end
      prev = cyc;
    end
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rr_drain got=timeout exp=idle");
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int c0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_x[7:0] = 8'd7;
    req_y[7:0] = 8'hF7;
    req_valid = 4'b0001;
    wait_accept(10, ok);
    total++;
    if (!ok || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL bp_acc got=%b exp=0001", req_ready);
    end
    @(posedge clk); #1;
    req_x[15:8] = 8'd5;
    req_y[15:8] = 8'd6;
    req_valid = 4'b0010;
    wait_resp(40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_resp got=timeout exp=resp");
    end
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c0 = cyc;
      total += 2;
      if (resp_valid !== 1'b1 || resp_prod !== 16'hFFC1 ||
          resp_id !== 2'd0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%h/%0d exp=1/ffc1/0",
                 i, resp_valid, resp_prod, resp_id);
      end
      if (req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_ready%0d got=%b exp=0000",
                 i, req_ready);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_accept(5, ok);
    total += 2;
    if (!ok || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_next got=%b exp=0010", req_ready);
    end
    if (cyc != c0 + 2) begin
      bad++;
      $display("FAIL bp_when got=%0d exp=%0d", cyc, c0 + 2);
    end
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_drain got=timeout exp=idle");
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_x[23:16] = 8'd9;
    req_y[23:16] = 8'd9;
    req_valid = 4'b0100;
    wait_accept(10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rm_acc got=timeout exp=accept");
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    req_x[31:24] = 8'd11;
    req_y[31:24] = 8'd12;
    req_x[15:8]  = 8'hF0;
    req_y[15:8]  = 8'd3;
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 4'b0000 || resp_prod !== 16'h0 ||
          resp_id !== 2'd0) begin
        bad++;
        $display("FAIL rm_out%0d got=%b%b%b/%h/%0d exp=000/0/0",
                 i, resp_valid, busy, |req_ready,
                 resp_prod, resp_id);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_accept(5, ok);
    total++;
    if (!ok || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL rm_gnt got=%b exp=0010", req_ready);
    end
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rm_drain got=timeout exp=idle");
    end
  endtask

  task automatic test_random;
    int target = 1500;
    int got = 0;
    logic [3:0] g;
    bit ok;
    req_valid = '0;
    for (int c = 0; c < 60000 && got < target; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      if (|g) got++;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_x[i*8 +: 8] = ($urandom_range(0, 7) == 0) ?
                            8'h80 : 8'($urandom);
          req_y[i*8 +: 8] = ($urandom_range(0, 7) == 0) ?
                            8'h80 : 8'($urandom);
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    total++;
    if (got != target) begin
      bad++;
      $display("FAIL rnd_count got=%0d exp=%0d", got, target);
    end
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rnd_drain got=timeout exp=idle");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_left got=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
